// File: rtl/led_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package     : led_ctrl_pkg
// Description : Shared types and encodings for the LED shift sequencer.
//               It defines the sequencer FSM states, the MODE input encodings
//               and the shift direction values.
// Revision    : 1.0 - initial release
// ============================================================================
package led_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

  localparam logic [1:0] MODE_ROL    = 2'b00;
  localparam logic [1:0] MODE_ROR    = 2'b01;
  localparam logic [1:0] MODE_BOUNCE = 2'b10;
  localparam logic [1:0] MODE_HOLD   = 2'b11;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage : led_ctrl_pkg
`default_nettype wire

// File: rtl/led_shift_sequencer_key_debounce.sv
`default_nettype none
// ============================================================================
// Module      : key_debounce
// Description : Conditions an active-low pushbutton. A 2-flop synchronizer
//               feeds a debounce counter. press_o pulses for one cycle when
//               the debounced level falls (key pressed). Key release
//               produces no pulse.
// Ports       : clk_i   - clock
//               rst_ni  - asynchronous active-low reset
//               key_i   - raw key, active-low, asynchronous to clk_i
//               level_o - debounced key level (1 = released)
//               press_o - one-cycle press pulse
// Revision    : 1.0 - initial release
// ============================================================================
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_i,
  output logic level_o,
  output logic press_o
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;

  // The synchronizer and the debounced level reset to "released", so a key
  // held through reset release must still be debounced into a press.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= key_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    press_d = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        press_d = ~sync2_q;  // only a 1->0 transition is a press
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign level_o = level_q;
  assign press_o = press_q;

endmodule : key_debounce
`default_nettype wire

// File: rtl/led_shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : led_shift_sequencer
// Description : Control block for the rotating LED shift register. It
//               generates the step tick, debounces the pause key, and drives
//               single-cycle LOAD / SHIFT_EN strobes for rotate-left,
//               rotate-right and bounce modes. All outputs are registered.
// Ports       : CLOCK_50   - clock
//               RST_N      - asynchronous active-low reset
//               KEY_PAUSE  - raw pause key, active-low
//               MODE       - 00 rol, 01 ror, 10 bounce, 11 hold
//               SPEED      - step rate select (only with LED_SPEED_SELECT_EN)
//               LED_STATE  - shifter contents fed back
//               SHIFT_EN   - one-cycle shift strobe
//               SHIFT_DIR  - 0 left, 1 right (valid with SHIFT_EN)
//               LOAD       - one-cycle load strobe
//               LOAD_VALUE - pattern to load (valid with LOAD, else 0)
//               PAUSED     - high while paused
// Options     : define LED_SPEED_SELECT_EN to add the SPEED input
//               (1x/2x/4x/8x step rate).
// Revision    : 1.0 - initial release
// ============================================================================
module led_shift_sequencer
  import led_ctrl_pkg::*;
#(
  parameter int                WIDTH           = 10,
  parameter int                PRESCALE_BITS   = 23,
  parameter int                DEBOUNCE_CYCLES = 1000000,
  parameter logic [WIDTH-1:0]  SEED            = WIDTH'(1)
) (
  input  logic             CLOCK_50,
  input  logic             RST_N,
  input  logic             KEY_PAUSE,
  input  logic [1:0]       MODE,
`ifdef LED_SPEED_SELECT_EN
  input  logic [1:0]       SPEED,
`endif
  input  logic [WIDTH-1:0] LED_STATE,
  output logic             SHIFT_EN,
  output logic             SHIFT_DIR,
  output logic             LOAD,
  output logic [WIDTH-1:0] LOAD_VALUE,
  output logic             PAUSED
);

  // --------------------------------------------------------------------------
  // Step timebase
  // --------------------------------------------------------------------------
  logic [PRESCALE_BITS-1:0] presc_q;
  logic                     tick;

  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + 1'b1;
    end
  end

`ifdef LED_SPEED_SELECT_EN
  // Only the low (PRESCALE_BITS - SPEED) bits must be all ones, so each
  // SPEED step halves the tick period.
  logic [PRESCALE_BITS-1:0] tick_mask;
  assign tick_mask = {PRESCALE_BITS{1'b1}} >> SPEED;
  assign tick      = &(presc_q | ~tick_mask);
`else
  assign tick = &presc_q;
`endif

  // --------------------------------------------------------------------------
  // Pause key
  // --------------------------------------------------------------------------
  logic press;
  logic key_level;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_pause (
    .clk_i  (CLOCK_50),
    .rst_ni (RST_N),
    .key_i  (KEY_PAUSE),
    .level_o(key_level),
    .press_o(press)
  );

  // Only the press pulse drives the sequencer; the level is kept for reuse.
  logic unused_level;
  assign unused_level = key_level;

  // --------------------------------------------------------------------------
  // Sequencer FSM
  // --------------------------------------------------------------------------
  state_e           state_q, state_d;
  logic             dir_q, dir_d;
  logic             shift_en_q, shift_en_d;
  logic             shift_dir_q, shift_dir_d;
  logic             load_q, load_d;
  logic [WIDTH-1:0] load_value_q, load_value_d;
  logic             paused_q, paused_d;

  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= ST_INIT;
      dir_q        <= DIR_LEFT;
      shift_en_q   <= 1'b0;
      shift_dir_q  <= DIR_LEFT;
      load_q       <= 1'b0;
      load_value_q <= '0;
      paused_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      dir_q        <= dir_d;
      shift_en_q   <= shift_en_d;
      shift_dir_q  <= shift_dir_d;
      load_q       <= load_d;
      load_value_q <= load_value_d;
      paused_q     <= paused_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    dir_d        = dir_q;
    shift_en_d   = 1'b0;
    shift_dir_d  = shift_dir_q;
    load_d       = 1'b0;
    load_value_d = '0;
    paused_d     = paused_q;

    case (state_q)
      ST_INIT: begin
        load_d       = 1'b1;
        load_value_d = SEED;
        state_d      = ST_RUN;
      end

      ST_RUN: begin
        // A press takes priority over a coincident tick.
        if (press) begin
          state_d  = ST_PAUSE;
          paused_d = 1'b1;
        end else if (tick && (MODE != MODE_HOLD)) begin
          if (LED_STATE == '0) begin
            // Empty shifter: reseed instead of shifting nothing around.
            load_d       = 1'b1;
            load_value_d = SEED;
          end else begin
            case (MODE)
              MODE_ROL: dir_d = DIR_LEFT;
              MODE_ROR: dir_d = DIR_RIGHT;
              MODE_BOUNCE: begin
                // Wall check uses the pattern before this shift, so the lit
                // bit reverses instead of wrapping around.
                if ((dir_q == DIR_LEFT) && LED_STATE[WIDTH-1]) begin
                  dir_d = DIR_RIGHT;
                end else if ((dir_q == DIR_RIGHT) && LED_STATE[0]) begin
                  dir_d = DIR_LEFT;
                end
              end
              default: dir_d = dir_q;
            endcase
            shift_en_d  = 1'b1;
            shift_dir_d = dir_d;
          end
        end
      end

      ST_PAUSE: begin
        if (press) begin
          state_d  = ST_RUN;
          paused_d = 1'b0;
        end
      end

      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  assign SHIFT_EN   = shift_en_q;
  assign SHIFT_DIR  = shift_dir_q;
  assign LOAD       = load_q;
  assign LOAD_VALUE = load_value_q;
  assign PAUSED     = paused_q;

endmodule : led_shift_sequencer
`default_nettype wire
